// File: rtl/uart_pkg.sv
// Shared definitions for the UART command path: byte/opcode widths and sequencer states.
package uart_pkg;
  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_OPND = 3'd1,
    ST_GET_OP   = 3'd2,
    ST_FIRE     = 3'd3,
    ST_WAIT_TX  = 3'd4
  } state_t;
endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap counter; o_expired flags the terminal count while counting is enabled.
module uart_gap_timer #(
  parameter int NB_TIMEOUT     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam logic [NB_TIMEOUT-1:0] LAST_CNT = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [NB_TIMEOUT-1:0] cnt_q, cnt_d;

  assign o_expired = i_enable && (cnt_q == LAST_CNT);

  // Holds at the terminal count so a stalled enable can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear)                       cnt_d = '0;
    else if (i_enable && !o_expired)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_cmd_sequencer.sv
// Assembles N_OPERANDS operand bytes plus an opcode byte, commits them atomically,
// requests transmission and blocks until the result transmitter reports done.
module uart_cmd_sequencer
  import uart_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEF,
  parameter int NB_OP          = NB_OP_DEF,
  parameter int N_OPERANDS     = 2,
  parameter int NB_TIMEOUT     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_valid,
  input  logic [NB_DATA-1:0]            i_data,
  input  logic                          i_tx_done,
  output logic [N_OPERANDS*NB_DATA-1:0] o_operands,
  output logic [NB_OP-1:0]              o_operation,
  output logic                          o_transmit,
  output logic                          o_busy,
  output logic                          o_timeout_err,
  output logic                          o_op_err,
  output logic                          o_drop
);
  localparam int                NB_IDX   = (N_OPERANDS > 1) ? $clog2(N_OPERANDS) : 1;
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_OPERANDS - 1);

  state_t                          state_q, state_d;
  logic [NB_IDX-1:0]               idx_q, idx_d;
  logic [N_OPERANDS*NB_DATA-1:0]   shadow_q, shadow_d;
  logic [N_OPERANDS*NB_DATA-1:0]   opnds_q, opnds_d;
  logic [NB_OP-1:0]                op_q, op_d;
  logic                            tout_q, tout_d;
  logic                            op_err_q, op_err_d;
  logic                            drop_q, drop_d;
  logic                            gap_clear, gap_enable, gap_expired;

  assign gap_enable = (state_q == ST_GET_OPND) || (state_q == ST_GET_OP);
  assign gap_clear  = i_valid || !gap_enable;

  uart_gap_timer #(
    .NB_TIMEOUT    (NB_TIMEOUT),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (gap_clear),
    .i_enable (gap_enable),
    .o_expired(gap_expired)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    opnds_d  = opnds_q;
    op_d     = op_q;
    tout_d   = 1'b0;
    op_err_d = 1'b0;
    drop_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          shadow_d[0 +: NB_DATA] = i_data;
          if (N_OPERANDS == 1) begin
            state_d = ST_GET_OP;
          end else begin
            idx_d   = NB_IDX'(1);
            state_d = ST_GET_OPND;
          end
        end
      end
      ST_GET_OPND: begin
        if (i_valid) begin
          shadow_d[idx_q*NB_DATA +: NB_DATA] = i_data;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_GET_OP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (gap_expired) begin
          idx_d   = '0;
          tout_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_GET_OP: begin
        // A byte arriving on the terminal count wins over the timeout.
        if (i_valid) begin
          if (|i_data[NB_DATA-1:NB_OP]) begin
            op_err_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            opnds_d = shadow_q;
            op_d    = i_data[NB_OP-1:0];
            state_d = ST_FIRE;
          end
        end else if (gap_expired) begin
          tout_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_FIRE: begin
        drop_d  = i_valid;
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        drop_d = i_valid;
        if (i_tx_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      opnds_q  <= '0;
      op_q     <= '0;
      tout_q   <= 1'b0;
      op_err_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      opnds_q  <= opnds_d;
      op_q     <= op_d;
      tout_q   <= tout_d;
      op_err_q <= op_err_d;
      drop_q   <= drop_d;
    end
  end

  assign o_operands    = opnds_q;
  assign o_operation   = op_q;
  assign o_transmit    = (state_q == ST_FIRE);
  assign o_busy        = (state_q == ST_FIRE) || (state_q == ST_WAIT_TX);
  assign o_timeout_err = tout_q;
  assign o_op_err      = op_err_q;
  assign o_drop        = drop_q;
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer: a 2-operand and a 3-operand instance, both with a 100-cycle gap limit.
module tb_uart_cmd_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [7:0]  data;
  logic        tx_done;

  logic [15:0] operands;
  logic [5:0]  operation;
  logic        transmit, busy, tout, operr, drop;

  logic [23:0] operands3;
  logic [5:0]  operation3;
  logic        transmit3, busy3, tout3, operr3, drop3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_cmd_sequencer #(
    .NB_DATA(8), .NB_OP(6), .N_OPERANDS(2), .NB_TIMEOUT(16), .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .i_data(data), .i_tx_done(tx_done),
    .o_operands(operands), .o_operation(operation), .o_transmit(transmit), .o_busy(busy),
    .o_timeout_err(tout), .o_op_err(operr), .o_drop(drop)
  );

  uart_cmd_sequencer #(
    .NB_DATA(8), .NB_OP(6), .N_OPERANDS(3), .NB_TIMEOUT(16), .TIMEOUT_CYCLES(100)
  ) dut3 (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .i_data(data), .i_tx_done(tx_done),
    .o_operands(operands3), .o_operation(operation3), .o_transmit(transmit3), .o_busy(busy3),
    .o_timeout_err(tout3), .o_op_err(operr3), .o_drop(drop3)
  );

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] b);
    valid = 1'b1;
    data  = b;
    step();
    valid = 1'b0;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    idle(3);
    vectors++; if (operands !== 16'h0) begin miscompares++; $display("FAIL rst_operands: got %h want 0000", operands); end
    vectors++; if (operation !== 6'h0) begin miscompares++; $display("FAIL rst_operation: got %h want 00", operation); end
    vectors++; if ({transmit, busy, tout, operr, drop} !== 5'b0) begin miscompares++; $display("FAIL rst_flags: got %b want 00000", {transmit, busy, tout, operr, drop}); end
    vectors++; if (operands3 !== 24'h0) begin miscompares++; $display("FAIL rst_operands3: got %h want 000000", operands3); end
    vectors++; if ({operation3, transmit3, busy3, tout3, operr3, drop3} !== 11'b0) begin miscompares++; $display("FAIL rst_flags3: got %b want 0", {operation3, transmit3, busy3, tout3, operr3, drop3}); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_cmd();
    send(8'h05); idle(19);
    send(8'h03); idle(19);
    send(8'h20);
    vectors++; if (transmit !== 1'b1) begin miscompares++; $display("FAIL basic_transmit: got %b want 1", transmit); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_fire: got %b want 1", busy); end
    vectors++; if (operands !== 16'h0305) begin miscompares++; $display("FAIL basic_operands: got %h want 0305", operands); end
    vectors++; if (operation !== 6'h20) begin miscompares++; $display("FAIL basic_operation: got %h want 20", operation); end
    step();
    vectors++; if (transmit !== 1'b0) begin miscompares++; $display("FAIL basic_transmit_once: got %b want 0", transmit); end
    idle(10);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_wait: got %b want 1", busy); end
    pulse_done();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_done: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    send(8'h11);
    idle(99);
    vectors++; if (tout !== 1'b0) begin miscompares++; $display("FAIL tout_early: got %b want 0", tout); end
    step();
    vectors++; if (tout !== 1'b1) begin miscompares++; $display("FAIL tout_pulse: got %b want 1", tout); end
    step();
    vectors++; if (tout !== 1'b0) begin miscompares++; $display("FAIL tout_single: got %b want 0", tout); end
    send(8'hAA); send(8'hBB); send(8'h08);
    vectors++; if (transmit !== 1'b1) begin miscompares++; $display("FAIL tout_recover_tx: got %b want 1", transmit); end
    vectors++; if (operands !== 16'hBBAA) begin miscompares++; $display("FAIL tout_recover_operands: got %h want BBAA", operands); end
    vectors++; if (operation !== 6'h08) begin miscompares++; $display("FAIL tout_recover_operation: got %h want 08", operation); end
    step(); pulse_done();
  endtask

  task automatic test_op_err();
    send(8'h01); send(8'h02); send(8'hE0);
    vectors++; if (operr !== 1'b1) begin miscompares++; $display("FAIL operr_pulse: got %b want 1", operr); end
    vectors++; if (transmit !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL operr_no_tx: got tx=%b busy=%b want 0 0", transmit, busy); end
    vectors++; if (operands !== 16'hBBAA) begin miscompares++; $display("FAIL operr_operands_held: got %h want BBAA", operands); end
    vectors++; if (operation !== 6'h08) begin miscompares++; $display("FAIL operr_operation_held: got %h want 08", operation); end
    step();
    vectors++; if (operr !== 1'b0) begin miscompares++; $display("FAIL operr_single: got %b want 0", operr); end
  endtask

  task automatic test_drop();
    send(8'h44); send(8'h55); send(8'h06);
    vectors++; if (operands !== 16'h5544 || operation !== 6'h06) begin miscompares++; $display("FAIL drop_setup: got %h/%h want 5544/06", operands, operation); end
    // Byte and done tick together in FIRE: byte dropped, done ignored.
    valid = 1'b1; data = 8'hFF; tx_done = 1'b1;
    step();
    valid = 1'b0; tx_done = 1'b0;
    vectors++; if (drop !== 1'b1) begin miscompares++; $display("FAIL drop_fire: got %b want 1", drop); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL fire_done_ignored: got busy=%b want 1", busy); end
    send(8'h7F);
    vectors++; if (drop !== 1'b1) begin miscompares++; $display("FAIL drop_wait: got %b want 1", drop); end
    vectors++; if (operands !== 16'h5544) begin miscompares++; $display("FAIL drop_not_stored: got %h want 5544", operands); end
    step();
    vectors++; if (drop !== 1'b0) begin miscompares++; $display("FAIL drop_single: got %b want 0", drop); end
    pulse_done();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL drop_done: got busy=%b want 0", busy); end
    send(8'h01); send(8'h02); send(8'h03);
    vectors++; if (operands !== 16'h0201 || operation !== 6'h03) begin miscompares++; $display("FAIL drop_next_cmd: got %h/%h want 0201/03", operands, operation); end
    step(); pulse_done();
  endtask

  task automatic test_reset_mid();
    send(8'h31); send(8'h32);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vectors++; if (operands !== 16'h0 || operation !== 6'h0) begin miscompares++; $display("FAIL midrst_committed: got %h/%h want 0000/00", operands, operation); end
    vectors++; if ({transmit, busy, tout, operr, drop} !== 5'b0) begin miscompares++; $display("FAIL midrst_flags: got %b want 00000", {transmit, busy, tout, operr, drop}); end
    send(8'h41); send(8'h42); send(8'h07);
    vectors++; if (transmit !== 1'b1) begin miscompares++; $display("FAIL midrst_tx: got %b want 1", transmit); end
    vectors++; if (operands !== 16'h4241 || operation !== 6'h07) begin miscompares++; $display("FAIL midrst_cmd: got %h/%h want 4241/07", operands, operation); end
    step(); pulse_done();
  endtask

  task automatic test_three_operands();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    // Each later byte lands exactly on the terminal gap count.
    send(8'h10); idle(99);
    send(8'h20);
    vectors++; if (tout3 !== 1'b0) begin miscompares++; $display("FAIL n3_tout_b2: got %b want 0", tout3); end
    idle(99);
    send(8'h30);
    vectors++; if (tout3 !== 1'b0) begin miscompares++; $display("FAIL n3_tout_b3: got %b want 0", tout3); end
    idle(99);
    send(8'h01);
    vectors++; if (transmit3 !== 1'b1 || busy3 !== 1'b1) begin miscompares++; $display("FAIL n3_tx: got tx=%b busy=%b want 1 1", transmit3, busy3); end
    vectors++; if (operands3 !== 24'h302010) begin miscompares++; $display("FAIL n3_operands: got %h want 302010", operands3); end
    vectors++; if (operation3 !== 6'h01) begin miscompares++; $display("FAIL n3_operation: got %h want 01", operation3); end
    vectors++; if ({tout3, operr3, drop3} !== 3'b0) begin miscompares++; $display("FAIL n3_no_err: got %b want 000", {tout3, operr3, drop3}); end
    step();
    vectors++; if (tout3 !== 1'b0) begin miscompares++; $display("FAIL n3_tout_late: got %b want 0", tout3); end
  endtask

  initial begin
    rst_n   = 1'b0;
    valid   = 1'b0;
    data    = 8'h00;
    tx_done = 1'b0;
    test_reset();
    test_basic_cmd();
    test_timeout();
    test_op_err();
    test_drop();
    test_reset_mid();
    test_three_operands();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
